// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU and a host loader/dump port.
// The CPU has priority; a starved host forces a one-cycle CPU stall to get a grant.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STARVE_LIMIT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic [DATA_WIDTH-1:0]    host_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    cpu_stall_q, cpu_stall_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    gnt;

  always_comb begin
    gnt = !rst && host_req &&
          ((state_q == STALL) || (!cpu_mem_read && !cpu_mem_write));

    if (gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      // the stalled CPU store is dropped; the CPU re-issues it next cycle
      mem_we    = !rst && cpu_mem_write && (state_q != STALL);
    end

    cnt_d = (host_req && !gnt) ? cnt_q + 5'd1 : 5'd0;

    if ((state_q == STALL) || !host_req || gnt) state_d = IDLE;
    else if (cnt_d == LIMIT)                     state_d = STALL;
    else                                         state_d = WAIT;

    cpu_stall_d = (state_d == STALL);
    rvalid_d    = gnt && !host_we;
    rdata_d     = rvalid_d ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      cpu_stall_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_stall_q <= cpu_stall_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cpu_rdata   = mem_rdata;
  assign cpu_stall   = cpu_stall_q;
  assign host_gnt    = gnt;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory attached.
module tb_dmem_arbiter;
  localparam int DW = 20;
  localparam int AW = 8;

  logic          clk, rst;
  logic          cpu_mem_read, cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] tbmem [0:255];
  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) tbmem[mem_addr] <= mem_wdata;
  assign mem_rdata = tbmem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change just after the falling edge; checks follow 1 time unit later
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 3 + 5);
  endfunction

  initial begin
    int ngnt;
    rst = 1'b1; cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // reset with a pending host request
    step(); #1;
    chk("rst_gnt", host_gnt, 0);
    chk("rst_we", mem_we, 0);
    step(); #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);

    // first cycle after reset: host write granted immediately
    step(); rst = 0; host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 20'hABCDE; #1;
    chk("wr_gnt", host_gnt, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_data", mem_wdata, 32'hABCDE);
    // back-to-back read
    step(); host_we = 0; #1;
    chk("rd_gnt", host_gnt, 1);
    chk("rd_we", mem_we, 0);
    chk("wr_no_rvalid", host_rvalid, 0);
    step(); host_req = 0; #1;
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 32'hABCDE);
    chk("rd_gnt_off", host_gnt, 0);
    step(); #1;
    chk("rd_rvalid_pulse", host_rvalid, 0);

    // starvation: CPU stores every cycle, host write pending to the same address
    step();
    cpu_mem_write = 1; cpu_addr = 8'h20; cpu_wdata = 20'h11111;
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 20'h22222;
    ngnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      #1;
      if (host_gnt || cpu_stall) ngnt++;
    end
    chk("starve_denied", ngnt, 0);
    step(); #1;
    chk("stall_on", cpu_stall, 1);
    chk("stall_gnt", host_gnt, 1);
    chk("stall_wdata", mem_wdata, 32'h22222);
    chk("stall_addr", mem_addr, 32'h20);
    step(); host_req = 0; #1;
    chk("stall_off", cpu_stall, 0);
    chk("reissue_gnt", host_gnt, 0);
    chk("host_wins", tbmem[8'h20], 32'h22222);
    chk("reissue_wdata", mem_wdata, 32'h11111);
    step(); cpu_mem_write = 0; #1;
    chk("cpu_overwrite", tbmem[8'h20], 32'h11111);

    // abort after 5 denied cycles, then re-request counts from zero
    step(); cpu_mem_read = 1; cpu_addr = 8'h05;
    host_req = 1; host_we = 1; host_addr = 8'h30; host_wdata = 20'h33333;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("abort_pre_gnt", host_gnt, 0);
    step(); host_req = 0; #1;
    chk("abort_gnt", host_gnt, 0);
    chk("abort_rvalid", host_rvalid, 0);
    step(); host_req = 1; #1;
    chk("abort_stall", cpu_stall, 0);
    ngnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      #1;
      if (host_gnt || cpu_stall) ngnt++;
    end
    chk("rereq_denied", ngnt, 0);
    step(); #1;
    chk("rereq_stall", cpu_stall, 1);
    chk("rereq_gnt", host_gnt, 1);
    step(); host_req = 0; cpu_mem_read = 0; #1;
    chk("rereq_mem", tbmem[8'h30], 32'h33333);
    chk("rereq_no_rvalid", host_rvalid, 0);

    // host drops request in the stall cycle: no grant, CPU store still dropped
    step(); cpu_mem_write = 1; cpu_addr = 8'h40; cpu_wdata = 20'h44444;
    host_req = 1; host_we = 1; host_addr = 8'h41; host_wdata = 20'h55555;
    for (int i = 0; i < 15; i++) step();
    #1;
    chk("viol_pre_stall", cpu_stall, 0);
    step(); host_req = 0; #1;
    chk("viol_stall", cpu_stall, 1);
    chk("viol_gnt", host_gnt, 0);
    chk("viol_we", mem_we, 0);
    step(); #1;
    chk("viol_stall_off", cpu_stall, 0);
    chk("viol_cpu_we", mem_we, 1);
    step(); cpu_mem_write = 0; #1;

    // reset during the grant cycle of a host read
    step(); host_req = 1; host_we = 0; host_addr = 8'h10; rst = 1; #1;
    chk("rstrd_gnt", host_gnt, 0);
    step(); rst = 0; host_req = 0; #1;
    chk("rstrd_rvalid", host_rvalid, 0);
    chk("rstrd_rdata", host_rdata, 0);
    chk("rstrd_stall", cpu_stall, 0);

    // stream 256 writes, then dump them back
    ngnt = 0;
    for (int a = 0; a < 256; a++) begin
      step(); host_req = 1; host_we = 1; host_addr = AW'(a); host_wdata = pat(a); #1;
      if (!host_gnt) ngnt++;
    end
    chk("stream_missed_gnts", ngnt, 0);
    for (int a = 0; a <= 256; a++) begin
      step();
      if (a < 256) begin host_req = 1; host_we = 0; host_addr = AW'(a); end
      else host_req = 0;
      #1;
      if (a > 0) begin
        chk("dump_rvalid", host_rvalid, 1);
        chk($sformatf("dump_%02h", a - 1), host_rdata, pat(a - 1));
      end
    end
    step(); #1;
    chk("dump_rvalid_end", host_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 20, the data memory word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, the data memory address width (256 words).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 16, the number of consecutive denied host cycles before a forced grant.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge system clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: cpu_mem_read  input  1  CPU load this cycle.
REQ-008 Port: cpu_mem_write  input  1  CPU store this cycle.
REQ-009 Port: cpu_addr  input  ADDRESS_WIDTH  CPU word address.
REQ-010 Port: cpu_wdata  input  DATA_WIDTH  CPU store data.
REQ-011 Port: cpu_rdata  output  DATA_WIDTH  mem_rdata passed through combinationally.
REQ-012 Port: cpu_stall  output  1  registered; holds CPU PC/state for the cycle.
REQ-013 Port: host_req  input  1  host (loader/dump) transaction request.
REQ-014 Port: host_we  input  1  host write (1) / read (0).
REQ-015 Port: host_addr  input  ADDRESS_WIDTH  host word address.
REQ-016 Port: host_wdata  input  DATA_WIDTH  host write data.
REQ-017 Port: host_gnt  output  1  one-cycle grant; transaction executes this cycle.
REQ-018 Port: host_rvalid  output  1  one-cycle pulse, host_rdata valid.
REQ-019 Port: host_rdata  output  DATA_WIDTH  registered host read data.
REQ-020 Port: mem_we  output  1  memory write enable.
REQ-021 Port: mem_addr  output  ADDRESS_WIDTH  memory address.
REQ-022 Port: mem_wdata  output  DATA_WIDTH  memory write data.
REQ-023 Port: mem_rdata  input  DATA_WIDTH  memory combinational read data.

Function
REQ-024 States SHALL be IDLE, WAIT, STALL; cpu_stall SHALL be 1 only in STALL.
REQ-025 CPU SHALL have priority: host_gnt=1 in a cycle only if (state=STALL) or (host_req=1 and cpu_mem_read=0 and cpu_mem_write=0).
REQ-026 When host_gnt=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_mem_write; when host_gnt=1, mem_addr=host_addr, mem_wdata=host_wdata, mem_we=host_we.
REQ-027 In STALL, CPU stores SHALL be suppressed; the stalled CPU re-issues next cycle.
REQ-028 Host SHALL hold host_req, host_we, host_addr, host_wdata stable until host_gnt; each grant completes exactly one transaction.
REQ-029 On a granted read, host_rdata SHALL capture mem_rdata at the end of the grant cycle and host_rvalid SHALL pulse the following cycle; granted writes SHALL produce no rvalid.
REQ-030 A 5-bit starve counter SHALL increment each cycle host_req=1 and host_gnt=0, and clear on grant or host_req=0.
REQ-031 IDLE->WAIT when host_req=1 and not granted; WAIT->STALL at the clock edge where the counter reaches STARVE_LIMIT; STALL->IDLE unconditionally after one cycle (grant occurs in STALL).
REQ-032 Any state->IDLE when host_req drops before grant (abort, counter cleared, no grant, no rvalid).
REQ-033 Back-to-back: host_req held high after a grant SHALL start a new transaction with counter 0; at most one grant per cycle.
REQ-034 If host_req=0 in STALL (protocol violation), no grant SHALL issue and the stall cycle still completes.
REQ-035 All 2^ADDRESS_WIDTH addresses SHALL be valid; no wrap or range checks.

Reset
REQ-036 While rst=1: state=IDLE, counter=0, cpu_stall=0, host_gnt=0, host_rvalid=0, host_rdata=0, mem_we=0; a pending host request or in-flight rvalid SHALL be discarded.
REQ-037 Reset asserted mid-transaction SHALL take effect at that clock edge; first grant possible in the first cycle after rst deasserts.

Verification
REQ-038 CPU idle, host write addr 0x10 data 0xABCDE -> host_gnt same cycle, mem_we=1, mem_addr=0x10; host read 0x10 -> host_rvalid next cycle, host_rdata=0xABCDE.
REQ-039 CPU store every cycle, host_req held -> no grant for 16 cycles, cpu_stall=1 on the 17th cycle with host_gnt=1, CPU store suppressed, cpu_stall=0 after.
REQ-040 CPU and host writes to 0x20 in the STALL cycle -> memory holds host data; CPU re-issue next cycle then overwrites with CPU data.
REQ-041 host_req dropped after 5 denied cycles -> state IDLE, counter 0, no grant/rvalid; re-request restarts count at 0.
REQ-042 rst pulsed in the grant cycle of a host read -> host_rvalid stays 0, host_rdata=0, cpu_stall=0.
REQ-043 Host streams 256 writes (0x00..0xFF) with CPU idle -> one grant per cycle, contents match on dump.
